cali_rls_pseg: RTL and testbench
================================

# cali_rls_pseg

Adaptive piecewise-polynomial DTC INL calibrator. It maps a normalized DTC phase request X in [0,1) to a DTC control word Y through per-segment polynomial coefficients. Coefficients adapt by LMS or RLS, driven by a measured phase error ERR that arrives a programmable number of cycles after the matching X. It sits in the fractional-output-divider control path, between the delta-sigma phase residue and the DTC code register. It is a behavioural, real-valued model.

## Interface
- ORDER, 2: polynomial order, 0..2; number of taps T = ORDER+1.
- MU, 2.0**-6: LMS step size.
- LAMBDA, 0.999: RLS forgetting factor.
- P_INIT, 100.0: RLS covariance diagonal at reset.
- CLK  in  1  clock; all state updates on the rising edge.
- NRST  in  1  reset; asynchronous, active-low.
- EN  in  1  adaptation enable; Y is still produced when EN=0.
- CALI_MODE_RLS  in  1  0 = LMS, 1 = RLS.
- X  in  real  normalized phase request, [0,1).
- sync_dly  in  3  ERR latency in cycles relative to X, 0..7.
- ERR  in  real  measured normalized phase error, signed, in cycles.
- PSEGS  in  2  log2 of segment count; NSEG = 2**PSEGS (1, 2, 4 or 8).
- KDTC_INIT  in  real  initial DTC gain, in codes per unit X.
- Y  out  real  DTC control word.

## Operation
- **Input conditioning:** X is clamped to [0, 1-2**-24].
- **Segment and local coordinate:** s = floor(X*NSEG), u = X*NSEG - s, with u in [0,1).
- **Regressor:** phi = [1, u, u**2], truncated to T entries.
- **Output function:** Y_next = sum over k of c[s][k]*phi[k].
- **Reset coefficients:**
  - c[s][0] = KDTC_INIT*s/NSEG
  - c[s][1] = KDTC_INIT/NSEG
  - c[s][2] = 0
  - This makes Y = KDTC_INIT*X exactly at reset.
- **Reset covariance:** every per-segment P = P_INIT*I (TxT).
- **Regressor history:** every cycle, independent of EN, the pair (s, phi) is pushed into an 8-deep history. The entry used for an update, (s_d, phi_d), is the one from sync_dly cycles earlier. sync_dly=0 uses the current cycle's pair.
- **Before history fills:** updates whose delayed entry predates reset are suppressed.
- **LMS update** (EN=1, mode 0): c[s_d][k] += MU*KDTC_INIT*ERR*phi_d[k]. Only segment s_d is touched.
- **RLS update** (EN=1, mode 1), applied to segment s_d only:
  - g = P*phi_d / (LAMBDA + phi_d' P phi_d)
  - c[s_d] += KDTC_INIT*ERR*g
  - P = (P - g*phi_d'*P)/LAMBDA
  - P is symmetrized after each update.
- **EN=0:** coefficients and P are frozen; the history keeps shifting.
- **Mode switch:** coefficients and P are retained.
- **Static inputs:** PSEGS and KDTC_INIT are sampled only during reset. Changing them takes effect at the next reset.

## Timing
- Y is registered: X at edge n gives Y after edge n+1, a 1-cycle latency.
- Y during reset is 0.0.
- The coefficient update at edge n uses the coefficients held before edge n. Y computed at edge n also uses those old coefficients.
- Updated coefficients affect Y from edge n+1.
- Reset asserted mid-operation immediately clears Y, the history and P, and restores the linear coefficients.

## Structure
- **Shared package `cali_rls_pkg`:**
  - constants MAX_SEG=8, MAX_TAP=3, HIST_DEPTH=8
  - typedefs for the coefficient array real [MAX_SEG][MAX_TAP]
  - typedef for the covariance array real [MAX_SEG][MAX_TAP][MAX_TAP]
  - typedef for the history entry
- **Sub-module `rls_tap_update`:** combinational single-segment RLS step. Inputs: P, phi, ERR scale, LAMBDA. Outputs: delta-c and the new P.
- LMS stays inline in the top module.

## Test plan
- **Reset and bypass:** NRST low, then high with KDTC_INIT=312, PSEGS=0, EN=0, X=0.5 -> Y=0 during reset and Y=156.0 one cycle after release. With X=0.25 -> Y=78.0.
- **Freeze:** EN=0, ERR=0.1 for 100 cycles, X=0.25 -> Y remains 78.0.
- **LMS single step:**
  - Setup: ORDER=2, PSEGS=0, sync_dly=0, X=0.5 constant, EN=1.
  - Stimulus: ERR=0.01 for one cycle, 0 otherwise.
  - Response: Y rises by 312*0.01/64*1.3125 = 0.063984.
- **Latency and segment select:**
  - Setup: PSEGS=1, sync_dly=2. X=0.25 at cycle 0, X=0.75 afterwards. ERR pulse of 0.01 at cycle 2 only.
  - Response: only segment 0 changes. Y for X=0.75 stays 234.0; Y for X=0.25 changes.
- **Convergence:** closed loop with ERR = (Ytrue(X_d) - Yused(X_d))/KDTC_INIT, where Ytrue = 312*X + 20*X*(1-X) and X is uniform random.
  - LMS, PSEGS=2: |Y - Ytrue| < 0.05 codes within 200k cycles.
  - RLS: same bound within 5k cycles.
- **Mid-run reset:** after convergence, pulse NRST -> Y=0, then Y=312*X on the next cycle.

Source files
------------

// File: rtl/cali_rls_pkg.sv
// Shared types and constants for the piecewise-polynomial DTC calibrator.
// Real-valued behavioural model.
package cali_rls_pkg;

  localparam int MAX_SEG    = 8;
  localparam int MAX_TAP    = 3;
  localparam int HIST_DEPTH = 8;

  localparam real X_MAX = 1.0 - 1.0 / 16777216.0;

  typedef real coef_t [MAX_SEG][MAX_TAP];
  typedef real cov_t  [MAX_SEG][MAX_TAP][MAX_TAP];
  typedef real mat_t  [MAX_TAP][MAX_TAP];
  typedef real phi_t  [MAX_TAP];
  typedef logic [2:0] seg_t;

  function automatic real clamp_x(input real x);
    if (x < 0.0) return 0.0;
    if (x > X_MAX) return X_MAX;
    return x;
  endfunction

endpackage

// File: rtl/rls_tap_update.sv
// One RLS step for a single segment: gain, coefficient delta and
// the symmetrized, forgetting-scaled covariance.
module rls_tap_update
  import cali_rls_pkg::*;
#(
  parameter int NTAP = MAX_TAP
) (
  input  mat_t p_i,
  input  phi_t phi_i,
  input  real  esc_i,
  input  real  lambda_i,
  output phi_t dc_o,
  output mat_t p_o
);

  phi_t pphi;
  phi_t ptp;
  phi_t g;
  mat_t a;
  real  den;

  always_comb begin
    den = lambda_i;
    for (int i = 0; i < MAX_TAP; i++) begin
      pphi[i] = 0.0;
      ptp[i]  = 0.0;
      for (int j = 0; j < MAX_TAP; j++) begin
        pphi[i] = pphi[i] + p_i[i][j] * phi_i[j];
        ptp[i]  = ptp[i] + phi_i[j] * p_i[j][i];
      end
    end
    for (int i = 0; i < MAX_TAP; i++)
      den = den + phi_i[i] * pphi[i];
    for (int i = 0; i < MAX_TAP; i++) begin
      g[i]    = pphi[i] / den;
      dc_o[i] = esc_i * g[i];
    end
    for (int i = 0; i < MAX_TAP; i++)
      for (int j = 0; j < MAX_TAP; j++)
        a[i][j] = (p_i[i][j] - g[i] * ptp[j]) / lambda_i;
    // Taps beyond the polynomial order keep their covariance untouched.
    for (int i = 0; i < MAX_TAP; i++)
      for (int j = 0; j < MAX_TAP; j++)
        p_o[i][j] = (i < NTAP && j < NTAP) ?
                    0.5 * (a[i][j] + a[j][i]) : p_i[i][j];
  end

endmodule

// File: rtl/cali_rls_pseg.sv
// Adaptive piecewise-polynomial DTC INL calibrator (LMS / RLS).
// Maps phase request X to DTC word Y with per-segment coefficients.
module cali_rls_pseg
  import cali_rls_pkg::*;
#(
  parameter int  ORDER  = 2,
  parameter real MU     = 0.015625,
  parameter real LAMBDA = 0.999,
  parameter real P_INIT = 100.0
) (
  input  logic       CLK,
  input  logic       NRST,
  input  logic       EN,
  input  logic       CALI_MODE_RLS,
  input  real        X,
  input  logic [2:0] sync_dly,
  input  real        ERR,
  input  logic [1:0] PSEGS,
  input  real        KDTC_INIT,
  output real        Y
);

  localparam int T = ORDER + 1;

  logic [1:0] psegs_q;
  real        kdtc_q;
  real        y_q, y_d;
  coef_t      c_q, c_d;
  cov_t       p_q, p_d;

  phi_t hphi_q [HIST_DEPTH-1];
  seg_t hseg_q [HIST_DEPTH-1];
  logic [HIST_DEPTH-2:0] hvld_q;

  int   nseg;
  int   seg_i;
  real  xn;
  real  u;
  real  init_w;
  real  esc;
  seg_t cur_seg;
  phi_t cur_phi;
  seg_t d_seg;
  phi_t d_phi;
  logic d_vld;
  logic [2:0] dix;
  mat_t p_sel;
  phi_t rls_dc;
  mat_t rls_p;

  assign init_w = KDTC_INIT / real'(1 << PSEGS);
  assign esc    = kdtc_q * ERR;
  assign dix    = sync_dly - 3'd1;
  assign Y      = y_q;

  always_comb begin
    nseg  = 1 << psegs_q;
    xn    = clamp_x(X) * real'(nseg);
    seg_i = $rtoi(xn);
    if (seg_i > nseg - 1) seg_i = nseg - 1;
    u          = xn - real'(seg_i);
    cur_seg    = seg_t'(seg_i);
    cur_phi[0] = 1.0;
    cur_phi[1] = (T > 1) ? u : 0.0;
    cur_phi[2] = (T > 2) ? u * u : 0.0;
    y_d = 0.0;
    for (int k = 0; k < MAX_TAP; k++)
      y_d = y_d + c_q[cur_seg][k] * cur_phi[k];
    // Delay 0 pairs the error with this cycle's own regressor.
    if (sync_dly == 3'd0) begin
      d_seg = cur_seg;
      d_phi = cur_phi;
      d_vld = 1'b1;
    end else begin
      d_seg = hseg_q[dix];
      d_phi = hphi_q[dix];
      d_vld = hvld_q[dix];
    end
    for (int i = 0; i < MAX_TAP; i++)
      for (int j = 0; j < MAX_TAP; j++)
        p_sel[i][j] = p_q[d_seg][i][j];
  end

  rls_tap_update #(
    .NTAP (T)
  ) u_rls (
    .p_i      (p_sel),
    .phi_i    (d_phi),
    .esc_i    (esc),
    .lambda_i (LAMBDA),
    .dc_o     (rls_dc),
    .p_o      (rls_p)
  );

  always_comb begin
    c_d = c_q;
    p_d = p_q;
    if (EN && d_vld) begin
      for (int k = 0; k < MAX_TAP; k++)
        if (CALI_MODE_RLS)
          c_d[d_seg][k] = c_q[d_seg][k] + rls_dc[k];
        else
          c_d[d_seg][k] = c_q[d_seg][k] + MU * esc * d_phi[k];
      if (CALI_MODE_RLS)
        for (int i = 0; i < MAX_TAP; i++)
          for (int j = 0; j < MAX_TAP; j++)
            p_d[d_seg][i][j] = rls_p[i][j];
    end
  end

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      psegs_q <= PSEGS;
      kdtc_q  <= KDTC_INIT;
      y_q     <= 0.0;
      hvld_q  <= '0;
      for (int s = 0; s < MAX_SEG; s++) begin
        c_q[s][0] <= init_w * real'(s);
        c_q[s][1] <= init_w;
        c_q[s][2] <= 0.0;
        for (int i = 0; i < MAX_TAP; i++)
          for (int j = 0; j < MAX_TAP; j++)
            p_q[s][i][j] <= (i == j) ? P_INIT : 0.0;
      end
      for (int h = 0; h < HIST_DEPTH - 1; h++) begin
        hseg_q[h] <= '0;
        for (int k = 0; k < MAX_TAP; k++)
          hphi_q[h][k] <= 0.0;
      end
    end else begin
      y_q    <= y_d;
      c_q    <= c_d;
      p_q    <= p_d;
      hvld_q <= {hvld_q[HIST_DEPTH-3:0], 1'b1};
      hseg_q[0] <= cur_seg;
      for (int k = 0; k < MAX_TAP; k++)
        hphi_q[0][k] <= cur_phi[k];
      for (int h = 1; h < HIST_DEPTH - 1; h++) begin
        hseg_q[h] <= hseg_q[h-1];
        for (int k = 0; k < MAX_TAP; k++)
          hphi_q[h][k] <= hphi_q[h-1][k];
      end
    end
  end

endmodule

// File: tb/tb_cali_rls_pseg.sv
// Directed bench for cali_rls_pseg: bypass, freeze, LMS step,
// history latency, segment select, RLS convergence, mid-run reset.
module tb_cali_rls_pseg;

  logic       clk;
  logic       nrst;
  logic       en;
  logic       mode;
  logic [2:0] sd;
  logic [1:0] psegs;
  real        x;
  real        err;
  real        kdtc;
  real        y;

  int n_tests;
  int n_fail;

  real xs;
  real yobs;

  cali_rls_pseg dut (
    .CLK           (clk),
    .NRST          (nrst),
    .EN            (en),
    .CALI_MODE_RLS (mode),
    .X             (x),
    .sync_dly      (sd),
    .ERR           (err),
    .PSEGS         (psegs),
    .KDTC_INIT     (kdtc),
    .Y             (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic real ytrue(input real v);
    return 312.0 * v + 20.0 * v * (1.0 - v);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input real obs,
                       input real exp, input real tol);
    n_tests++;
    assert ((obs - exp) <= tol && (exp - obs) <= tol) else begin
      n_fail++;
      $error("FAIL %s: observed %0.9f required %0.9f", tag, obs, exp);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    nrst  = 1'b0;
    en    = 1'b0;
    mode  = 1'b0;
    sd    = 3'd0;
    psegs = 2'd0;
    x     = 0.5;
    err   = 0.0;
    kdtc  = 312.0;

    tick();
    tick();
    check("rst_y", y, 0.0, 1e-12);

    nrst = 1'b1;
    tick();
    check("byp_half", y, 156.0, 1e-9);
    x = 0.25;
    tick();
    check("byp_qtr", y, 78.0, 1e-9);

    err = 0.1;
    repeat (100) tick();
    check("freeze", y, 78.0, 1e-9);

    x = 1.0;
    tick();
    check("clamp_hi", y, 312.0 * (1.0 - 1.0 / 16777216.0), 1e-9);
    x = -0.5;
    tick();
    check("clamp_lo", y, 0.0, 1e-9);

    x   = 0.5;
    err = 0.0;
    en  = 1'b1;
    tick();
    check("lms_pre", y, 156.0, 1e-9);
    err = 0.01;
    tick();
    check("lms_same_edge", y, 156.0, 1e-9);
    err = 0.0;
    tick();
    check("lms_step", y, 156.063984375, 1e-9);
    en = 1'b0;

    sd   = 3'd3;
    nrst = 1'b0;
    tick();
    check("rst2_y", y, 0.0, 1e-12);
    nrst = 1'b1;
    x    = 0.5;
    en   = 1'b1;
    err  = 0.01;
    tick();
    tick();
    tick();
    check("hist_pre", y, 156.0, 1e-9);
    err = 0.0;
    tick();
    tick();
    check("hist_suppress", y, 156.0, 1e-9);
    err = 0.01;
    tick();
    err = 0.0;
    tick();
    check("hist_valid", y, 156.063984375, 1e-9);

    en    = 1'b0;
    psegs = 2'd1;
    sd    = 3'd2;
    nrst  = 1'b0;
    tick();
    nrst = 1'b1;
    x    = 0.75;
    en   = 1'b1;
    tick();
    tick();
    tick();
    check("seg1_base", y, 234.0, 1e-9);
    x = 0.25;
    tick();
    check("seg0_base", y, 78.0, 1e-9);
    x = 0.75;
    tick();
    check("seg1_c1", y, 234.0, 1e-9);
    err = 0.01;
    tick();
    check("seg1_c2", y, 234.0, 1e-9);
    err = 0.0;
    tick();
    check("seg1_untouched", y, 234.0, 1e-9);
    en = 1'b0;
    x  = 0.25;
    tick();
    check("seg0_updated", y, 78.063984375, 1e-9);

    psegs = 2'd2;
    sd    = 3'd1;
    mode  = 1'b1;
    nrst  = 1'b0;
    tick();
    nrst = 1'b1;
    for (int i = 0; i < 800; i++) begin
      xs  = real'($urandom_range(0, 999999)) / 1.0e6;
      x   = xs;
      en  = 1'b0;
      err = 0.0;
      tick();
      yobs = y;
      err  = (ytrue(xs) - yobs) / 312.0;
      en   = 1'b1;
      tick();
    end
    en  = 1'b0;
    err = 0.0;
    x = 0.05;
    tick();
    check("rls_conv_005", y, ytrue(0.05), 0.05);
    x = 0.3;
    tick();
    check("rls_conv_030", y, ytrue(0.3), 0.05);
    x = 0.55;
    tick();
    check("rls_conv_055", y, ytrue(0.55), 0.05);
    x = 0.8;
    tick();
    check("rls_conv_080", y, ytrue(0.8), 0.05);
    x = 0.97;
    tick();
    check("rls_conv_097", y, ytrue(0.97), 0.05);

    nrst = 1'b0;
    #1;
    check("midrst_async", y, 0.0, 1e-12);
    tick();
    x    = 0.3;
    nrst = 1'b1;
    tick();
    check("midrst_lin", y, 312.0 * 0.3, 1e-9);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
